// File: rtl/gray_mon_pkg.sv
// Shared definitions for the Gray-count sequence monitor: the monitor FSM
// state encoding, the Gray word width and the Gray-to-binary decode.
package gray_mon_pkg;

  localparam int GRAY_W = 4;

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    LOCKED  = 2'd1,
    FAULT   = 2'd2
  } mon_state_t;

  // Binary decode of a reflected Gray word: each binary bit is the XOR of
  // all Gray bits at or above its position.
  function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] g);
    logic [GRAY_W-1:0] b;
    b[GRAY_W-1] = g[GRAY_W-1];
    for (int i = GRAY_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_seq_monitor_if.sv
// Bundle between the Gray counter stage (master: drives the count stream,
// observes status) and the sequence monitor (slave: observes the stream,
// drives status).
interface gray_seq_monitor_if #(
  parameter int ERRCNT_W = 8
);
  import gray_mon_pkg::*;

  logic [GRAY_W-1:0]   gray_in;
  logic                gray_valid;
  logic [GRAY_W-1:0]   bin_out;
  logic                bin_valid;
  logic                lock;
  logic                step_err;
  logic                err_type;
  logic                err_sticky;
  logic                wrap;
  logic [ERRCNT_W-1:0] err_count;

  modport master (
    output gray_in, gray_valid,
    input  bin_out, bin_valid, lock, step_err, err_type, err_sticky, wrap, err_count
  );

  modport slave (
    input  gray_in, gray_valid,
    output bin_out, bin_valid, lock, step_err, err_type, err_sticky, wrap, err_count
  );

endinterface

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary decoder for one Gray word.
module gray_to_bin
  import gray_mon_pkg::*;
(
  input  logic [GRAY_W-1:0] gray,
  output logic [GRAY_W-1:0] bin
);

  assign bin = gray2bin(gray);

endmodule

// File: rtl/gray_seq_monitor.sv
// Gray-count sequence monitor. Decodes each valid Gray sample, checks it is
// the modulo-16 successor of the previous sample, and reports lock, step
// errors (with a Hamming-distance qualifier), wraps and a sticky error flag.
// Optional feature macro GRAY_SEQ_MON_ERRCNT_EN: when defined, err_count is a
// saturating ERRCNT_W-bit counter of step_err pulses; otherwise it is tied 0.
module gray_seq_monitor
  import gray_mon_pkg::*;
#(
  parameter int LOCK_CNT = 2,
  parameter int ERRCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  gray_seq_monitor_if.slave bus
);

  localparam logic [3:0] LOCK_CNT_V = 4'(LOCK_CNT);

  mon_state_t        state_reg, state_next;
  logic [GRAY_W-1:0] prev_bin_reg, prev_bin_next;
  logic [GRAY_W-1:0] prev_gray_reg, prev_gray_next;
  logic              have_ref_reg, have_ref_next;
  logic [3:0]        good_run_reg, good_run_next;

  logic [GRAY_W-1:0] bin_out_reg, bin_out_next;
  logic              bin_valid_reg, bin_valid_next;
  logic              lock_reg, lock_next;
  logic              step_err_reg, step_err_next;
  logic              err_type_reg, err_type_next;
  logic              err_sticky_reg, err_sticky_next;
  logic              wrap_reg, wrap_next;

  logic [GRAY_W-1:0] dec_bin;
  logic [GRAY_W-1:0] succ_bin;
  logic [GRAY_W-1:0] gray_diff;
  logic              is_succ;
  logic              ham_one;
  logic [3:0]        good_run_inc;

  gray_to_bin u_dec (
    .gray (bus.gray_in),
    .bin  (dec_bin)
  );

  // Successor and single-bit-change tests against the stored reference.
  always_comb begin
    succ_bin     = prev_bin_reg + 4'd1;
    is_succ      = (dec_bin == succ_bin);
    gray_diff    = bus.gray_in ^ prev_gray_reg;
    ham_one      = (gray_diff != 4'd0) && ((gray_diff & (gray_diff - 4'd1)) == 4'd0);
    good_run_inc = (good_run_reg >= LOCK_CNT_V) ? LOCK_CNT_V : good_run_reg + 4'd1;
  end

  // Next-state and registered-output decisions for one sample.
  always_comb begin
    state_next      = state_reg;
    prev_bin_next   = prev_bin_reg;
    prev_gray_next  = prev_gray_reg;
    have_ref_next   = have_ref_reg;
    good_run_next   = good_run_reg;
    bin_out_next    = bin_out_reg;
    bin_valid_next  = 1'b0;
    step_err_next   = 1'b0;
    err_type_next   = err_type_reg;
    err_sticky_next = err_sticky_reg;
    wrap_next       = 1'b0;

    if (bus.gray_valid) begin
      // Every valid sample becomes the reference for the next one.
      bin_out_next   = dec_bin;
      bin_valid_next = 1'b1;
      prev_bin_next  = dec_bin;
      prev_gray_next = bus.gray_in;
      have_ref_next  = 1'b1;

      case (state_reg)
        LOCKED: begin
          if (is_succ) begin
            wrap_next = (prev_bin_reg == 4'hF);
          end else begin
            step_err_next   = 1'b1;
            err_type_next   = ~ham_one;
            err_sticky_next = 1'b1;
            good_run_next   = 4'd0;
            state_next      = FAULT;
          end
        end
        default: begin
          // ACQUIRE and FAULT resync silently.
          if (!have_ref_reg) begin
            good_run_next = 4'd0;
          end else if (is_succ) begin
            good_run_next = good_run_inc;
            if (good_run_inc == LOCK_CNT_V) begin
              state_next = LOCKED;
            end
          end else begin
            good_run_next = 4'd0;
          end
        end
      endcase
    end

    lock_next = (state_next == LOCKED);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ACQUIRE;
      prev_bin_reg   <= '0;
      prev_gray_reg  <= '0;
      have_ref_reg   <= 1'b0;
      good_run_reg   <= 4'd0;
      bin_out_reg    <= '0;
      bin_valid_reg  <= 1'b0;
      lock_reg       <= 1'b0;
      step_err_reg   <= 1'b0;
      err_type_reg   <= 1'b0;
      err_sticky_reg <= 1'b0;
      wrap_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      prev_bin_reg   <= prev_bin_next;
      prev_gray_reg  <= prev_gray_next;
      have_ref_reg   <= have_ref_next;
      good_run_reg   <= good_run_next;
      bin_out_reg    <= bin_out_next;
      bin_valid_reg  <= bin_valid_next;
      lock_reg       <= lock_next;
      step_err_reg   <= step_err_next;
      err_type_reg   <= err_type_next;
      err_sticky_reg <= err_sticky_next;
      wrap_reg       <= wrap_next;
    end
  end

`ifdef GRAY_SEQ_MON_ERRCNT_EN
  logic [ERRCNT_W-1:0] err_count_reg;

  // Saturating count of step errors; holds at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count_reg <= '0;
    end else if (step_err_next && (err_count_reg != {ERRCNT_W{1'b1}})) begin
      err_count_reg <= err_count_reg + 1'b1;
    end
  end

  assign bus.err_count = err_count_reg;
`else
  assign bus.err_count = {ERRCNT_W{1'b0}};
`endif

  assign bus.bin_out    = bin_out_reg;
  assign bus.bin_valid  = bin_valid_reg;
  assign bus.lock       = lock_reg;
  assign bus.step_err   = step_err_reg;
  assign bus.err_type   = err_type_reg;
  assign bus.err_sticky = err_sticky_reg;
  assign bus.wrap       = wrap_reg;

endmodule
